// File: rtl/control_types_pkg.sv
// Shared control types for the MEM stage: memory op encoding, access FSM states
// and the alignment check used by the optional misalignment trap.
package control_types_pkg;

    typedef enum logic [2:0] {
        MEM_NONE,
        MEM_B,
        MEM_H,
        MEM_W,
        MEM_BU,
        MEM_HU
    } mem_op_t;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_ACCESS,
        MS_DONE
    } mem_fsm_t;

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        logic mis;
        case (op)
            MEM_H, MEM_HU: mis = off[0];
            MEM_W:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write data,
// and load byte/half extraction with sign or zero extension.
module mem_lane_align
    import control_types_pkg::*;
(
    input  mem_op_t     op,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (op)
            MEM_B, MEM_BU: begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            MEM_H, MEM_HU: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            MEM_W:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        // Loads always fetch the whole word; the lane is picked on return.
        if (!we) begin
            be = 4'b1111;
        end
    end

    always_comb begin
        rd_byte = rdata[7:0];
        case (off)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = off[1] ? rdata[31:16] : rdata[15:0];

        load_data = 32'h0;
        case (op)
            MEM_B:   load_data = {{24{rd_byte[7]}}, rd_byte};
            MEM_BU:  load_data = {24'h0, rd_byte};
            MEM_H:   load_data = {{16{rd_half[15]}}, rd_half};
            MEM_HU:  load_data = {16'h0, rd_half};
            MEM_W:   load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack transaction, lane steering, load return
// and pipeline stall. Optional MISALIGN_TRAP_EN traps misaligned half/word accesses.
//
// state     | meaning
// MS_IDLE   | waiting for a memory op; stalls the pipe if one is present
// MS_ACCESS | dmem_req held until ack or timeout
// MS_DONE   | result/flags valid for one cycle; pipeline advances
module mem_access_unit
    import control_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  mem_op_t     mem_ctrl_mem,
    input  logic        mem_do_write_ctrl_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] mem_data_in_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_mem,
    output logic        mem_stall,
    output logic        mem_bus_err,
    output logic        mem_misalign
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    mem_fsm_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      load_q;
    logic             err_q;
    logic             trap;
    logic             timeout_hit;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_load;

    mem_lane_align u_lane (
        .op         (mem_ctrl_mem),
        .we         (mem_do_write_ctrl_mem),
        .off        (alu_result_mem[1:0]),
        .store_data (mem_data_in_mem),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = is_misaligned(mem_ctrl_mem, alu_result_mem[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (state_q == MS_IDLE) && (mem_ctrl_mem != MEM_NONE) && trap;
        end
    end

    assign mem_misalign = mis_q;
`else
    assign trap         = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign dmem_addr     = {alu_result_mem[31:2], 2'b00};
    assign dmem_wdata    = lane_wdata;
    assign load_data_mem = load_q;
    assign mem_bus_err   = err_q;

    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        dmem_be   = 4'b0000;
        mem_stall = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (mem_ctrl_mem != MEM_NONE) begin
                    mem_stall = 1'b1;
                    state_d   = trap ? MS_DONE : MS_ACCESS;
                end
            end
            MS_ACCESS: begin
                dmem_req  = 1'b1;
                dmem_we   = mem_do_write_ctrl_mem;
                dmem_be   = lane_be;
                mem_stall = 1'b1;
                if (dmem_ack || timeout_hit) begin
                    state_d = MS_DONE;
                end
            end
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
        // The IDLE stall is combinational from the op, so keep it quiet while in reset.
        if (!rst_n) begin
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            load_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    cnt_q <= '0;
                    if ((mem_ctrl_mem != MEM_NONE) && trap) begin
                        load_q <= 32'h0;
                    end
                end
                MS_ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dmem_ack) begin
                        load_q <= mem_do_write_ctrl_mem ? 32'h0 : lane_load;
                    end else if (timeout_hit) begin
                        load_q <= 32'h0;
                        err_q  <= 1'b1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expected responses,
// a monitor checks them whenever a transaction completes.
module tb_mem_access_unit;
    import control_types_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] load;
        logic        chk_load;
        logic        err;
        logic        mis;
        int          req_n;
        int          stall_n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    mem_op_t     mem_ctrl_mem;
    logic        mem_do_write_ctrl_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] mem_data_in_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_mem;
    logic        mem_stall;
    logic        mem_bus_err;
    logic        mem_misalign;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mem_ctrl_mem          (mem_ctrl_mem),
        .mem_do_write_ctrl_mem (mem_do_write_ctrl_mem),
        .alu_result_mem        (alu_result_mem),
        .mem_data_in_mem       (mem_data_in_mem),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_be               (dmem_be),
        .dmem_wdata            (dmem_wdata),
        .dmem_ack              (dmem_ack),
        .dmem_rdata            (dmem_rdata),
        .load_data_mem         (load_data_mem),
        .mem_stall             (mem_stall),
        .mem_bus_err           (mem_bus_err),
        .mem_misalign          (mem_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [3:0] be, input logic we,
                                    input logic [31:0] wd, input logic [31:0] ld, input logic cl,
                                    input logic err, input logic mis, input int rn, input int sn);
        exp_t e;
        e.addr = a; e.be = be; e.we = we; e.wdata = wd; e.load = ld; e.chk_load = cl;
        e.err = err; e.mis = mis; e.req_n = rn; e.stall_n = sn;
        return e;
    endfunction

    // Issue one op, act as the memory slave (ack in the ack_n-th request cycle, 0 = never),
    // and return once the completion cycle has been reached.
    task automatic run_op(input mem_op_t op, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input int ack_n,
                          input exp_t e);
        int  cnt;
        bit  done;
        sb_q.push_back(e);
        @(negedge clk);
        mem_ctrl_mem          = op;
        mem_do_write_ctrl_mem = we;
        alu_result_mem        = addr;
        mem_data_in_mem       = data;
        dmem_rdata            = rdata;
        dmem_ack              = 1'b0;
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (dmem_req) cnt++;
            dmem_ack = (ack_n != 0) && (cnt == ack_n);
            if (!mem_stall) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL op_complete: got no completion want completion within 40 cycles");
        end
        mem_ctrl_mem = MEM_NONE;
        @(negedge clk);
        dmem_ack = 1'b0;
    endtask

    // Monitor: collects per-transaction observations and checks them at completion.
    initial begin
        int          rq;
        int          st;
        bit          in_txn;
        bit          unstable;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic [3:0]  c_be;
        logic        c_we;
        exp_t        e;
        rq = 0; st = 0; in_txn = 1'b0; unstable = 1'b0;
        c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                rq = 0; st = 0; in_txn = 1'b0; unstable = 1'b0;
            end else begin
                if (dmem_req) begin
                    if (rq == 0) begin
                        c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
                    end else if (dmem_addr !== c_addr || dmem_wdata !== c_wdata ||
                                 dmem_be !== c_be || dmem_we !== c_we) begin
                        unstable = 1'b1;
                    end
                    rq++;
                end
                if (mem_stall) begin
                    in_txn = 1'b1;
                    st++;
                end else if (in_txn) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected_done: got completion want none");
                    end else begin
                        e = sb_q.pop_front();
                        chk("req_cycles", rq, e.req_n);
                        chk("stall_cycles", st, e.stall_n);
                        chk("bus_err", {31'h0, mem_bus_err}, {31'h0, e.err});
                        chk("misalign", {31'h0, mem_misalign}, {31'h0, e.mis});
                        chk("done_req_low", {31'h0, dmem_req}, 32'h0);
                        if (e.chk_load) chk("load_data", load_data_mem, e.load);
                        if (e.req_n > 0 && rq > 0) begin
                            chk("addr", c_addr, e.addr);
                            chk("be", {28'h0, c_be}, {28'h0, e.be});
                            chk("we", {31'h0, c_we}, {31'h0, e.we});
                            if (e.we) chk("wdata", c_wdata, e.wdata);
                            chk("stable", {31'h0, unstable}, 32'h0);
                        end
                    end
                    in_txn = 1'b0; rq = 0; st = 0; unstable = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end want end before 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n                 = 1'b0;
        mem_ctrl_mem          = MEM_W;
        mem_do_write_ctrl_mem = 1'b0;
        alu_result_mem        = 32'h100;
        mem_data_in_mem       = 32'h0;
        dmem_ack              = 1'b0;
        dmem_rdata            = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_load", load_data_mem, 32'h0);
        chk("rst_be", {28'h0, dmem_be}, 32'h0);
        chk("rst_err", {31'h0, mem_bus_err}, 32'h0);
        chk("rst_mis", {31'h0, mem_misalign}, 32'h0);
        mem_ctrl_mem = MEM_NONE;
        rst_n        = 1'b1;
        @(negedge clk);
        chk("idle_none_stall", {31'h0, mem_stall}, 32'h0);

        run_op(MEM_W,  1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1,
               mk_exp(32'h100, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1, 2));
        run_op(MEM_B,  1'b1, 32'h103, 32'h000000A5, 32'h0, 3,
               mk_exp(32'h100, 4'b1000, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0, 3, 4));
        run_op(MEM_B,  1'b0, 32'h102, 32'h0, 32'h00800000, 1,
               mk_exp(32'h100, 4'hF, 1'b0, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 1, 2));
        run_op(MEM_BU, 1'b0, 32'h102, 32'h0, 32'h00800000, 1,
               mk_exp(32'h100, 4'hF, 1'b0, 32'h0, 32'h00000080, 1'b1, 1'b0, 1'b0, 1, 2));
        run_op(MEM_HU, 1'b0, 32'h002, 32'h0, 32'h80010000, 1,
               mk_exp(32'h000, 4'hF, 1'b0, 32'h0, 32'h00008001, 1'b1, 1'b0, 1'b0, 1, 2));
        run_op(MEM_H,  1'b0, 32'h002, 32'h0, 32'h80010000, 1,
               mk_exp(32'h000, 4'hF, 1'b0, 32'h0, 32'hFFFF8001, 1'b1, 1'b0, 1'b0, 1, 2));
        run_op(MEM_H,  1'b1, 32'h102, 32'h1234ABCD, 32'h0, 2,
               mk_exp(32'h100, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0, 1'b0, 1'b0, 1'b0, 2, 3));
        run_op(MEM_W,  1'b1, 32'h204, 32'hCAFEF00D, 32'h0, 1,
               mk_exp(32'h204, 4'hF, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0, 1, 2));
        run_op(MEM_B,  1'b0, 32'h201, 32'h0, 32'h12347F56, 2,
               mk_exp(32'h200, 4'hF, 1'b0, 32'h0, 32'h0000007F, 1'b1, 1'b0, 1'b0, 2, 3));
        run_op(MEM_W,  1'b0, 32'h100, 32'h0, 32'hFFFFFFFF, 0,
               mk_exp(32'h100, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4, 5));

        // Reset dropped while a request is outstanding.
        @(negedge clk);
        mem_ctrl_mem          = MEM_W;
        mem_do_write_ctrl_mem = 1'b0;
        alu_result_mem        = 32'h300;
        @(negedge clk);
        chk("rstmid_req_before", {31'h0, dmem_req}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_req_after", {31'h0, dmem_req}, 32'h0);
        chk("rstmid_err", {31'h0, mem_bus_err}, 32'h0);
        mem_ctrl_mem = MEM_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_idle_req", {31'h0, dmem_req}, 32'h0);

`ifdef MISALIGN_TRAP_EN
        run_op(MEM_W, 1'b0, 32'h101, 32'h0, 32'h11223344, 1,
               mk_exp(32'h100, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 1));
`else
        run_op(MEM_W, 1'b0, 32'h101, 32'h0, 32'h11223344, 1,
               mk_exp(32'h100, 4'hF, 1'b0, 32'h0, 32'h11223344, 1'b1, 1'b0, 1'b0, 1, 2));
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
